// File: rtl/simplerisc_pkg.sv
// Shared SimpleRISC pipeline types and constants used by the memory-access stage.
package simplerisc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } dm_state_t;

    localparam int          DM_TIMEOUT_DEFAULT = 64;
    localparam logic [31:0] DM_LD_ERR_VALUE    = 32'hDEADBEEF;

endpackage

// File: rtl/dm_access_stage_if.sv
// Request/acknowledge data-memory port between the DM stage and the data memory.
interface dm_access_stage_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );

endinterface

// File: rtl/dm_timeout_counter.sv
// Counts consecutive REQ cycles; expired flags the last allowed cycle without an ack.
module dm_timeout_counter #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // count_reg holds the number of REQ cycles already completed
    assign expired = enable && (count_reg == W'(LIMIT - 1));

endmodule

// File: rtl/dm_access_stage.sv
// SimpleRISC memory-access stage: turns DM-stage load/store flags into one memory transaction.
// Optional request timeout with sticky error flag is built when DM_TIMEOUT_EN is defined.
module dm_access_stage
    import simplerisc_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = DM_TIMEOUT_DEFAULT,
    parameter logic [31:0] LD_ERR_VALUE   = DM_LD_ERR_VALUE
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      is_Ld_DM,
    input  logic                      is_St_DM,
    input  logic [31:0]               aluResult_DM,
    input  logic [31:0]               op2_DM,
    dm_access_stage_if.master         mem,
    output logic [31:0]               ldResult_DM,
    output logic                      stall_DM,
    output logic                      err_DM
);

    dm_state_t   state_reg;
    logic        req_reg;
    logic        we_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [31:0] ld_reg;
    logic        memop;

    assign memop = is_Ld_DM | is_St_DM;

`ifdef DM_TIMEOUT_EN
    logic tmo_expired;
    logic err_reg;

    dm_timeout_counter #(
        .LIMIT   (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_reg != REQ),
        .enable  (state_reg == REQ),
        .expired (tmo_expired)
    );

    assign err_DM = err_reg;
`else
    assign err_DM = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            req_reg   <= 1'b0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            ld_reg    <= '0;
`ifdef DM_TIMEOUT_EN
            err_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (memop) begin
                        addr_reg  <= aluResult_DM;
                        we_reg    <= is_St_DM & ~is_Ld_DM;
                        wdata_reg <= op2_DM;
                        req_reg   <= 1'b1;
                        state_reg <= REQ;
                    end
                end
                REQ: begin
                    // an ack arriving in the timeout cycle takes priority
                    if (mem.mem_ack) begin
                        req_reg   <= 1'b0;
                        if (!we_reg) begin
                            ld_reg <= mem.mem_rdata;
                        end
                        state_reg <= DONE;
                    end
`ifdef DM_TIMEOUT_EN
                    else if (tmo_expired) begin
                        req_reg   <= 1'b0;
                        if (!we_reg) begin
                            ld_reg <= LD_ERR_VALUE;
                        end
                        err_reg   <= 1'b1;
                        state_reg <= DONE;
                    end
`endif
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    req_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign stall_DM      = ((state_reg == IDLE) && memop) || (state_reg == REQ);
    assign mem.mem_req   = req_reg;
    assign mem.mem_we    = we_reg;
    assign mem.mem_addr  = addr_reg;
    assign mem.mem_wdata = wdata_reg;
    assign ldResult_DM   = ld_reg;

endmodule

// File: tb/tb_dm_access_stage.sv
// Randomized self-checking bench for dm_access_stage against a transaction-level model.
module tb_dm_access_stage;

    localparam int          TMO     = 4;
    localparam logic [31:0] ERR_VAL = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        is_Ld_DM;
    logic        is_St_DM;
    logic [31:0] aluResult_DM;
    logic [31:0] op2_DM;
    wire  [31:0] ldResult_DM;
    wire         stall_DM;
    wire         err_DM;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_ld  = 32'h0;
    logic        exp_err = 1'b0;

    dm_access_stage_if mem ();

    dm_access_stage #(
        .TIMEOUT_CYCLES (TMO),
        .LD_ERR_VALUE   (ERR_VAL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .is_Ld_DM     (is_Ld_DM),
        .is_St_DM     (is_St_DM),
        .aluResult_DM (aluResult_DM),
        .op2_DM       (op2_DM),
        .mem          (mem),
        .ldResult_DM  (ldResult_DM),
        .stall_DM     (stall_DM),
        .err_DM       (err_DM)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One memory op: delay = REQ cycle in which ack is given, 0 = never ack.
    // Expected: REQ lasts delay (or TMO) cycles, stall = REQ+1, occupancy = REQ+2.
    task automatic do_op(input logic ld, input logic st, input logic [31:0] addr,
                         input logic [31:0] data, input int delay, input logic [31:0] rdata);
        int  stalls;
        int  reqc;
        int  cycles;
        int  exp_reqc;
        bit  done;
        bit  is_load;
        stalls   = 0;
        reqc     = 0;
        cycles   = 1;
        done     = 0;
        is_load  = ld;
        exp_reqc = (delay == 0) ? TMO : delay;
        @(posedge clk); #1;
        is_Ld_DM = ld; is_St_DM = st; aluResult_DM = addr; op2_DM = data;
        mem.mem_ack = 1'b0;
        #1;
        if (stall_DM) stalls++;
        for (int c = 0; c < exp_reqc + 20 && !done; c++) begin
            @(posedge clk); #1;
            cycles++;
            if (mem.mem_req) begin
                reqc++;
                if (stall_DM) stalls++;
                tests++;
                if (mem.mem_we !== (st & ~ld) || mem.mem_addr !== addr || mem.mem_wdata !== data) begin
                    fails++;
                    $display("FAIL req_fields: we=%0b addr=%h wdata=%h required we=%0b addr=%h wdata=%h",
                             mem.mem_we, mem.mem_addr, mem.mem_wdata, st & ~ld, addr, data);
                end
                mem.mem_ack   = (reqc == delay);
                mem.mem_rdata = (reqc == delay) ? rdata : $urandom;
            end else begin
                done = 1;
                mem.mem_ack = 1'b0;
                tests++;
                if (c == 0) begin
                    fails++;
                    $display("FAIL req_latency: mem_req=0 one cycle after IDLE, required 1");
                end else begin
                    if (is_load) exp_ld = (delay == 0) ? ERR_VAL : rdata;
                    if (delay == 0) exp_err = 1'b1;
                    if (reqc !== exp_reqc) begin
                        fails++;
                        $display("FAIL req_cycles: got %0d required %0d", reqc, exp_reqc);
                    end
                    tests++;
                    if (stalls !== exp_reqc + 1 || stall_DM !== 1'b0) begin
                        fails++;
                        $display("FAIL stall_cycles: got %0d (done stall=%0b) required %0d (0)",
                                 stalls, stall_DM, exp_reqc + 1);
                    end
                    tests++;
                    if (cycles !== exp_reqc + 2) begin
                        fails++;
                        $display("FAIL occupancy: got %0d required %0d", cycles, exp_reqc + 2);
                    end
                    tests++;
                    if (ldResult_DM !== exp_ld) begin
                        fails++;
                        $display("FAIL ld_result: got %h required %h", ldResult_DM, exp_ld);
                    end
                    tests++;
                    if (err_DM !== exp_err) begin
                        fails++;
                        $display("FAIL err_flag: got %0b required %0b", err_DM, exp_err);
                    end
                end
            end
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL op_bound: transaction did not reach DONE within budget");
        end
        $display("[TB] op ld=%0b st=%0b addr=%h wdata=%h delay=%0d stalls=%0d ld_result=%h err=%0b",
                 ld, st, addr, data, delay, stalls, ldResult_DM, err_DM);
    endtask

    task automatic test_reset();
        rst = 1'b1; is_Ld_DM = 0; is_St_DM = 0; aluResult_DM = '0; op2_DM = '0;
        mem.mem_ack = 0; mem.mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (mem.mem_req !== 0 || mem.mem_we !== 0 || mem.mem_addr !== 0 || mem.mem_wdata !== 0 ||
            ldResult_DM !== 0 || err_DM !== 0 || stall_DM !== 0) begin
            fails++;
            $display("FAIL reset_values: req=%0b we=%0b addr=%h wdata=%h ld=%h err=%0b stall=%0b required all 0",
                     mem.mem_req, mem.mem_we, mem.mem_addr, mem.mem_wdata, ldResult_DM, err_DM, stall_DM);
        end
        is_Ld_DM = 1; #1;
        tests++;
        if (stall_DM !== 1'b1) begin
            fails++;
            $display("FAIL reset_stall_eq: got %0b required 1", stall_DM);
        end
        is_Ld_DM = 0;
        @(negedge clk); rst = 1'b0;
        exp_ld = '0; exp_err = 0;
        $display("[TB] reset done");
    endtask

    task automatic test_load();
        do_op(1'b1, 1'b0, 32'h100, $urandom, 1, 32'h12345678);
    endtask

    task automatic test_store();
        do_op(1'b0, 1'b1, 32'h200, 32'hCAFEF00D, 5, $urandom);
    endtask

    task automatic test_alu_then_load();
        @(posedge clk); #1;
        is_Ld_DM = 0; is_St_DM = 0; aluResult_DM = $urandom; op2_DM = $urandom;
        #1;
        tests++;
        if (stall_DM !== 1'b0) begin
            fails++;
            $display("FAIL alu_stall: got %0b required 0", stall_DM);
        end
        @(posedge clk); #1;
        tests++;
        if (mem.mem_req !== 1'b0 || ldResult_DM !== exp_ld) begin
            fails++;
            $display("FAIL alu_passthru: req=%0b ld=%h required req=0 ld=%h", mem.mem_req, ldResult_DM, exp_ld);
        end
        $display("[TB] alu op passed with zero stall");
        do_op(1'b1, 1'b0, $urandom, $urandom, 2, $urandom);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            logic ld;
            logic st;
            int   dly;
            ld = 1'($urandom_range(0, 1));
            st = ld ? 1'($urandom_range(0, 1)) : 1'b1;
`ifdef DM_TIMEOUT_EN
            dly = $urandom_range(1, TMO - 1);
`else
            dly = $urandom_range(1, 6);
`endif
            do_op(ld, st, $urandom, $urandom, dly, $urandom);
        end
    endtask

    task automatic test_spurious_ack();
        @(posedge clk); #1;
        is_Ld_DM = 0; is_St_DM = 0;
        mem.mem_ack = 1'b1; mem.mem_rdata = $urandom;
        @(posedge clk); #1;
        mem.mem_ack = 1'b0;
        tests++;
        if (mem.mem_req !== 1'b0 || stall_DM !== 1'b0 || ldResult_DM !== exp_ld) begin
            fails++;
            $display("FAIL spurious_ack: req=%0b stall=%0b ld=%h required req=0 stall=0 ld=%h",
                     mem.mem_req, stall_DM, ldResult_DM, exp_ld);
        end
        $display("[TB] spurious ack in IDLE ignored");
        do_op(1'b1, 1'b0, $urandom, $urandom, 1, $urandom);
    endtask

    task automatic test_reset_mid();
        int reqc;
        reqc = 0;
        @(posedge clk); #1;
        is_Ld_DM = 1; is_St_DM = 0; aluResult_DM = 32'h300; op2_DM = $urandom;
        mem.mem_ack = 0;
        for (int c = 0; c < 10 && reqc < 3; c++) begin
            @(posedge clk); #1;
            if (mem.mem_req) reqc++;
        end
        tests++;
        if (reqc !== 3) begin
            fails++;
            $display("FAIL reset_mid_setup: REQ cycles %0d required 3", reqc);
        end
        #2;
        rst = 1'b1; is_Ld_DM = 0;
        #1;
        tests++;
        if (mem.mem_req !== 1'b0 || ldResult_DM !== 32'h0 || stall_DM !== 1'b0 || mem.mem_addr !== 32'h0) begin
            fails++;
            $display("FAIL reset_mid_abort: req=%0b ld=%h stall=%0b addr=%h required 0 0 0 0",
                     mem.mem_req, ldResult_DM, stall_DM, mem.mem_addr);
        end
        exp_ld = '0; exp_err = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        mem.mem_ack = 1'b1; mem.mem_rdata = 32'h55555555;
        @(posedge clk); #1;
        mem.mem_ack = 1'b0;
        tests++;
        if (mem.mem_req !== 1'b0 || ldResult_DM !== exp_ld) begin
            fails++;
            $display("FAIL late_ack: req=%0b ld=%h required req=0 ld=%h", mem.mem_req, ldResult_DM, exp_ld);
        end
        $display("[TB] reset mid-transaction aborted, late ack ignored");
        do_op(1'b0, 1'b1, $urandom, $urandom, 3, $urandom);
    endtask

`ifdef DM_TIMEOUT_EN
    task automatic test_timeout();
        do_op(1'b1, 1'b0, 32'h400, $urandom, 0, $urandom);
        do_op(1'b1, 1'b0, 32'h404, $urandom, TMO, 32'h0BADF00D);
        do_op(1'b0, 1'b1, 32'h408, $urandom, 0, $urandom);
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_store();
        test_alu_then_load();
        test_back_to_back();
        test_spurious_ack();
        test_reset_mid();
`ifdef DM_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dm_access_stage.md
# dm_access_stage

Memory-access stage of the SimpleRISC pipeline, sitting directly downstream of the ALU→DM pipeline register and upstream of the DM→RW register. It turns the registered load/store flags, effective address and store data into a request/acknowledge transaction on the data-memory port. It returns load data and holds the upstream pipeline registers with a stall while a transaction is outstanding.

## Interface
Parameters:
- TIMEOUT_CYCLES, 64, REQ cycles without mem_ack before abort (used only with DM_TIMEOUT_EN)
- LD_ERR_VALUE, 32'hDEADBEEF, load result returned on timeout

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- is_Ld_DM  in  1  instruction in DM stage is a load
- is_St_DM  in  1  instruction in DM stage is a store
- aluResult_DM  in  32  effective address
- op2_DM  in  32  store data
- mem_req  out  1  request valid (registered)
- mem_we  out  1  1 = write, 0 = read (registered)
- mem_addr  out  32  request address (registered)
- mem_wdata  out  32  write data (registered)
- mem_rdata  in  32  read data, valid with mem_ack
- mem_ack  in  1  one-cycle acknowledge from memory
- ldResult_DM  out  32  captured load data to DM→RW register
- stall_DM  out  1  hold upstream stages (drives stall_ALUDM and earlier)
- err_DM  out  1  sticky timeout flag

## Operation
- FSM states: IDLE, REQ, DONE.
- memop = is_Ld_DM | is_St_DM. Both high is illegal and is treated as a load.
- IDLE: on memop, latch mem_addr=aluResult_DM, mem_we=is_St_DM & ~is_Ld_DM, mem_wdata=op2_DM, set mem_req=1, go to REQ. Otherwise stay idle.
- REQ: mem_req and request fields held stable until mem_ack is sampled high. On ack: mem_req←0; for reads ldResult_DM←mem_rdata, for writes ldResult_DM unchanged; go to DONE.
- DONE: single cycle, unconditional return to IDLE. The upstream register advances at this edge, so the completed op is never reissued.
- stall_DM = (IDLE & memop) | REQ. It is combinational from the inputs in IDLE.
- mem_ack outside REQ is ignored.
- Non-memory instructions pass with zero stall; ldResult_DM is not updated.

## Timing
- Reset values: state IDLE, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, ldResult_DM 0, err_DM 0. stall_DM follows its equation (0 unless memop).
- Reset mid-transaction: immediate abort to IDLE, mem_req drops asynchronously, and no result is captured.
- Minimum occupancy is 3 cycles (IDLE→REQ→DONE) with ack in the first REQ cycle. stall_DM is high for 2 of those cycles.
- Occupancy with ack k cycles after mem_req rises: k+2 cycles.
- Back-to-back memops: the next op enters IDLE the cycle after DONE; there are no bubble cycles beyond DONE.
- ldResult_DM is valid from the DONE cycle until the next load capture.

## Configuration
- DM_TIMEOUT_EN defined:
  - A cycle counter runs in REQ and clears on entry to REQ.
  - When TIMEOUT_CYCLES cycles pass with no ack: mem_req←0, ldResult_DM←LD_ERR_VALUE for loads, err_DM←1 (sticky until rst), go to DONE.
  - An ack in the same cycle as the timeout wins.
- DM_TIMEOUT_EN undefined: REQ waits indefinitely, err_DM tied 0, no counter logic is present.

## Structure
- Shared package simplerisc_pkg holds:
  - dm_state_t enum (IDLE, REQ, DONE)
  - DM_TIMEOUT_DEFAULT = 64
  - DM_LD_ERR_VALUE = 32'hDEADBEEF
- One sub-module, dm_timeout_counter (clear, enable, expired), instantiated only under DM_TIMEOUT_EN.

## Test plan
- Load addr 0x100, ack after 1 cycle with rdata 0x12345678 → mem_we=0, mem_addr=0x100, stall high for 2 cycles, ldResult_DM=0x12345678 in DONE.
- Store addr 0x200, data 0xCAFEF00D, ack delayed 5 cycles → mem_we=1, wdata stable for all REQ cycles, stall high for 6 cycles, ldResult_DM unchanged.
- ALU op (no ld/st) followed by a load → zero stall for the ALU op. The load's mem_req is asserted the cycle after it enters IDLE.
- rst asserted on the 3rd REQ cycle → mem_req=0 immediately, state IDLE, ldResult_DM=0, no capture from a late ack.
- Spurious mem_ack in IDLE → ignored, no state change.
- With DM_TIMEOUT_EN and TIMEOUT_CYCLES=4, load never acked → DONE after 4 REQ cycles, ldResult_DM=0xDEADBEEF, err_DM=1 and stays 1 across the next successful op.
